// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared CPU definitions: opcodes, ALU opcodes, controller state and class encodings
//
// Purpose: one place for the instruction opcodes, ALU opcode constants and the
// control_unit state/class encodings, so the datapath and benches agree with
// the controller. No ports (package).
package cpu_defs;

  // Instruction opcodes, IR_Data[31:27]
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU opcodes understood by the datapath ALU
  localparam logic [4:0] ALU_OP_ADD = 5'b00011;
  localparam logic [4:0] ALU_OP_AND = 5'b00101;
  localparam logic [4:0] ALU_OP_OR  = 5'b00110;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_F0     = 4'd1,
    S_F1     = 4'd2,
    S_F2     = 4'd3,
    S_DECODE = 4'd4,
    S_E3     = 4'd5,
    S_E4     = 4'd6,
    S_E5     = 4'd7,
    S_E6     = 4'd8,
    S_E7     = 4'd9,
    S_HALT   = 4'd10
  } state_t;

  // Instruction class latched in DECODE. Bit 2 marks the immediate-ALU group;
  // the low bits then pick the ALU operation so E4 needs no IR access.
  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_LDI  = 3'd1,
    CLS_LD   = 3'd2,
    CLS_ST   = 3'd3,
    CLS_ADDI = 3'd4,
    CLS_ANDI = 3'd5,
    CLS_ORI  = 3'd6
  } cls_t;

  function automatic cls_t op_class(input logic [4:0] op);
    op_class = CLS_NONE;
    case (op)
      OP_LDI:  op_class = CLS_LDI;
      OP_LD:   op_class = CLS_LD;
      OP_ST:   op_class = CLS_ST;
      OP_ADDI: op_class = CLS_ADDI;
      OP_ANDI: op_class = CLS_ANDI;
      OP_ORI:  op_class = CLS_ORI;
      default: op_class = CLS_NONE;
    endcase
  endfunction

  function automatic logic op_legal(input logic [4:0] op);
    op_legal = (op == OP_LD)   || (op == OP_LDI)  || (op == OP_ST)  ||
               (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) ||
               (op == OP_NOP)  || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/control_unit.sv
// rtl/control_unit.sv - Moore fetch/decode/execute sequencer driving datapath controls
//
// Purpose: steps the datapath through F0-F2, DECODE and E3-E7 for
// ld/ldi/st/addi/andi/ori/nop/halt, one control step per clock.
// Ports:
//   clk, reset_n (async active-low)     clock and reset
//   start                               leave IDLE/HALT and begin fetching
//   mem_wait                            memory not ready; holds F1/E6(ld)/E7(st)
//   IR_Data[31:0]                       instruction register, opcode in [31:27]
//   *_enable, read/write, Gra/Grb/BAout register enables, memory strobes, selects
//   *_select                            bus source selects (one-hot or zero)
//   alu_instruction[4:0]                ALU opcode
//   run                                 high outside IDLE/HALT
//   illegal_op                          pulse in DECODE for an unknown opcode
module control_unit
  import cpu_defs::*;
#(
  parameter logic [4:0] ALU_ADD = ALU_OP_ADD,
  parameter logic [4:0] ALU_AND = ALU_OP_AND,
  parameter logic [4:0] ALU_OR  = ALU_OP_OR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        mem_wait,
  input  logic [31:0] IR_Data,
  output logic        PC_enable,
  output logic        PC_increment_enable,
  output logic        IR_enable,
  output logic        Y_enable,
  output logic        Z_enable,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        r_enable,
  output logic        read,
  output logic        write,
  output logic        Gra,
  output logic        Grb,
  output logic        BAout,
  output logic        PC_select,
  output logic        Z_LO_select,
  output logic        MDR_select,
  output logic        c_select,
  output logic        r_select,
  output logic [4:0]  alu_instruction,
  output logic        run,
  output logic        illegal_op
);

  state_t     state;
  cls_t       cls;
  logic [4:0] opcode;
  logic       ir_low_unused;
  logic       cls_imm;
  logic       cls_mem;

  assign opcode        = IR_Data[31:27];
  assign ir_low_unused = ^IR_Data[26:0];
  assign cls_imm       = cls[2];
  assign cls_mem       = (cls == CLS_LD) || (cls == CLS_ST);

  // Next-state and class register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cls   <= CLS_NONE;
    end else begin
      case (state)
        S_IDLE, S_HALT: if (start) state <= S_F0;
        S_F0:           state <= S_F1;
        S_F1:           if (!mem_wait) state <= S_F2;
        S_F2:           state <= S_DECODE;
        S_DECODE: begin
          cls <= op_class(opcode);
          if (opcode == OP_HALT)
            state <= S_HALT;
          else if (op_class(opcode) == CLS_NONE)
            state <= S_F0;              // nop and illegal opcodes
          else
            state <= S_E3;
        end
        S_E3:           state <= S_E4;
        S_E4:           state <= S_E5;
        S_E5:           state <= cls_mem ? S_E6 : S_F0;
        S_E6: begin
          // Only the load read waits here; the store E6 is a register transfer.
          if (cls != CLS_LD || !mem_wait) state <= S_E7;
        end
        S_E7: begin
          if (cls != CLS_ST || !mem_wait) state <= S_F0;
        end
        default:        state <= S_IDLE;
      endcase
    end
  end

  // Output decode from state/class only (PC_increment_enable also sees mem_wait)
  always_comb begin
    PC_enable           = 1'b0;   // reserved for branches
    PC_increment_enable = 1'b0;
    IR_enable           = 1'b0;
    Y_enable            = 1'b0;
    Z_enable            = 1'b0;
    MAR_enable          = 1'b0;
    MDR_enable          = 1'b0;
    r_enable            = 1'b0;
    read                = 1'b0;
    write               = 1'b0;
    Gra                 = 1'b0;
    Grb                 = 1'b0;
    BAout               = 1'b0;
    PC_select           = 1'b0;
    Z_LO_select         = 1'b0;
    MDR_select          = 1'b0;
    c_select            = 1'b0;
    r_select            = 1'b0;
    alu_instruction     = 5'b00000;
    run                 = (state != S_IDLE) && (state != S_HALT);
    illegal_op          = 1'b0;

    case (state)
      S_F0: begin
        PC_select  = 1'b1;
        MAR_enable = 1'b1;
      end
      S_F1: begin
        read                = 1'b1;
        MDR_enable          = 1'b1;
        // Bump PC only on the cycle the fetch actually completes.
        PC_increment_enable = !mem_wait;
      end
      S_F2: begin
        MDR_select = 1'b1;
        IR_enable  = 1'b1;
      end
      S_DECODE: begin
        illegal_op = !op_legal(opcode);
      end
      S_E3: begin
        Y_enable = 1'b1;
        if (cls_imm) begin
          c_select = 1'b1;
        end else begin
          Grb   = 1'b1;
          BAout = 1'b1;
        end
      end
      S_E4: begin
        Z_enable = 1'b1;
        if (cls_imm) begin
          Grb      = 1'b1;
          r_select = 1'b1;
          case (cls)
            CLS_ANDI: alu_instruction = ALU_AND;
            CLS_ORI:  alu_instruction = ALU_OR;
            default:  alu_instruction = ALU_ADD;
          endcase
        end else begin
          c_select        = 1'b1;
          alu_instruction = ALU_ADD;
        end
      end
      S_E5: begin
        Z_LO_select = 1'b1;
        if (cls_mem) begin
          MAR_enable = 1'b1;
        end else begin
          Gra      = 1'b1;
          r_enable = 1'b1;
        end
      end
      S_E6: begin
        MDR_enable = 1'b1;
        if (cls == CLS_LD) begin
          read = 1'b1;
        end else begin
          Gra      = 1'b1;
          r_select = 1'b1;
        end
      end
      S_E7: begin
        if (cls == CLS_LD) begin
          MDR_select = 1'b1;
          Gra        = 1'b1;
          r_enable   = 1'b1;
        end else begin
          write = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        mem_wait;
  logic [31:0] IR_Data;
  logic PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable;
  logic MAR_enable, MDR_enable, r_enable, read, write, Gra, Grb, BAout;
  logic PC_select, Z_LO_select, MDR_select, c_select, r_select;
  logic [4:0] alu_instruction;
  logic run, illegal_op;

  control_unit dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mem_wait(mem_wait), .IR_Data(IR_Data),
    .PC_enable(PC_enable), .PC_increment_enable(PC_increment_enable), .IR_enable(IR_enable),
    .Y_enable(Y_enable), .Z_enable(Z_enable), .MAR_enable(MAR_enable), .MDR_enable(MDR_enable),
    .r_enable(r_enable), .read(read), .write(write), .Gra(Gra), .Grb(Grb), .BAout(BAout),
    .PC_select(PC_select), .Z_LO_select(Z_LO_select), .MDR_select(MDR_select),
    .c_select(c_select), .r_select(r_select), .alu_instruction(alu_instruction),
    .run(run), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  logic [24:0] ctrl;
  assign ctrl = {PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable, MAR_enable,
                 MDR_enable, r_enable, read, write, Gra, Grb, BAout, PC_select, Z_LO_select,
                 MDR_select, c_select, r_select, alu_instruction, run, illegal_op};

  localparam logic [24:0] B_PCINC = 25'd1 << 23;
  localparam logic [24:0] B_IREN  = 25'd1 << 22;
  localparam logic [24:0] B_YEN   = 25'd1 << 21;
  localparam logic [24:0] B_ZEN   = 25'd1 << 20;
  localparam logic [24:0] B_MAREN = 25'd1 << 19;
  localparam logic [24:0] B_MDREN = 25'd1 << 18;
  localparam logic [24:0] B_REN   = 25'd1 << 17;
  localparam logic [24:0] B_READ  = 25'd1 << 16;
  localparam logic [24:0] B_WRITE = 25'd1 << 15;
  localparam logic [24:0] B_GRA   = 25'd1 << 14;
  localparam logic [24:0] B_GRB   = 25'd1 << 13;
  localparam logic [24:0] B_BAOUT = 25'd1 << 12;
  localparam logic [24:0] B_PCSEL = 25'd1 << 11;
  localparam logic [24:0] B_ZLO   = 25'd1 << 10;
  localparam logic [24:0] B_MDRS  = 25'd1 << 9;
  localparam logic [24:0] B_CSEL  = 25'd1 << 8;
  localparam logic [24:0] B_RSEL  = 25'd1 << 7;
  localparam logic [24:0] A_ADD   = 25'd3 << 2;
  localparam logic [24:0] A_AND   = 25'd5 << 2;
  localparam logic [24:0] A_OR    = 25'd6 << 2;
  localparam logic [24:0] B_RUN   = 25'd1 << 1;
  localparam logic [24:0] B_ILL   = 25'd1;

  localparam logic [24:0] X_IDLE  = 25'd0;
  localparam logic [24:0] X_F0    = B_RUN | B_PCSEL | B_MAREN;
  localparam logic [24:0] X_F1W   = B_RUN | B_READ | B_MDREN;
  localparam logic [24:0] X_F1    = X_F1W | B_PCINC;
  localparam logic [24:0] X_F2    = B_RUN | B_MDRS | B_IREN;
  localparam logic [24:0] X_DEC   = B_RUN;
  localparam logic [24:0] X_DECI  = B_RUN | B_ILL;
  localparam logic [24:0] X_AE3   = B_RUN | B_GRB | B_BAOUT | B_YEN;
  localparam logic [24:0] X_AE4   = B_RUN | B_CSEL | B_ZEN | A_ADD;
  localparam logic [24:0] X_WB5   = B_RUN | B_ZLO | B_GRA | B_REN;
  localparam logic [24:0] X_IE3   = B_RUN | B_CSEL | B_YEN;
  localparam logic [24:0] X_IE4   = B_RUN | B_GRB | B_RSEL | B_ZEN;
  localparam logic [24:0] X_ME5   = B_RUN | B_ZLO | B_MAREN;
  localparam logic [24:0] X_LE6   = B_RUN | B_READ | B_MDREN;
  localparam logic [24:0] X_LE7   = B_RUN | B_MDRS | B_GRA | B_REN;
  localparam logic [24:0] X_SE6   = B_RUN | B_GRA | B_RSEL | B_MDREN;
  localparam logic [24:0] X_SE7   = B_RUN | B_WRITE;

  int errors = 0;
  int checks = 0;
  int ncyc   = 0;
  int pcinc  = 0;

  task automatic check(input string tag, input logic [24:0] got, input logic [24:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; mw is the mem_wait level for the cycle just entered.
  task automatic step(input string tag, input logic [24:0] exp, input logic mw);
    @(posedge clk);
    #1;
    mem_wait = mw;
    #1;
    ncyc++;
    if (PC_increment_enable) pcinc++;
    check(tag, ctrl, exp);
  endtask

  function automatic logic [31:0] ir(input logic [4:0] op);
    ir = {op, 27'h1234567};
  endfunction

  // From F0: fetch, decode, immediate-ALU execute, back to F0.
  task automatic run_imm(input string tag, input logic [4:0] op, input logic [24:0] alu);
    IR_Data = ir(op);
    step({tag, "_f1"}, X_F1, 1'b0);
    step({tag, "_f2"}, X_F2, 1'b0);
    step({tag, "_dec"}, X_DEC, 1'b0);
    step({tag, "_e3"}, X_IE3, 1'b0);
    IR_Data = ir(5'b11011);   // IR changes after DECODE must not matter
    step({tag, "_e4"}, X_IE4 | alu, 1'b0);
    step({tag, "_e5"}, X_WB5, 1'b0);
    step({tag, "_f0"}, X_F0, 1'b0);
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    mem_wait = 1'b0;
    IR_Data  = 32'd0;
    #1;
    check("reset_outputs", ctrl, X_IDLE);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step("idle", X_IDLE, 1'b0);

    // ldi, with start held high throughout (ignored outside IDLE/HALT)
    IR_Data = ir(5'b00001);
    start = 1'b1;
    step("ldi_f0", X_F0, 1'b0);
    ncyc = 0;
    step("ldi_f1", X_F1, 1'b0);
    step("ldi_f2", X_F2, 1'b0);
    step("ldi_dec", X_DEC, 1'b0);
    step("ldi_e3", X_AE3, 1'b0);
    step("ldi_e4", X_AE4, 1'b0);
    step("ldi_e5", X_WB5, 1'b0);
    step("ldi_f0_again", X_F0, 1'b0);
    start = 1'b0;
    check("ldi_latency", 25'(ncyc), 25'd7);

    run_imm("addi", 5'b01100, A_ADD);
    run_imm("andi", 5'b01101, A_AND);
    run_imm("ori",  5'b01110, A_OR);

    // nop: 4 cycles F0 to F0
    IR_Data = ir(5'b11010);
    ncyc = 0;
    step("nop_f1", X_F1, 1'b0);
    step("nop_f2", X_F2, 1'b0);
    step("nop_dec", X_DEC, 1'b0);
    step("nop_f0", X_F0, 1'b0);
    check("nop_latency", 25'(ncyc), 25'd4);

    // ld with 2 wait cycles in F1 and in E6
    IR_Data = ir(5'b00000);
    ncyc = 0;
    pcinc = 0;
    step("ld_f1_w1", X_F1W, 1'b1);
    step("ld_f1_w2", X_F1W, 1'b1);
    step("ld_f1", X_F1, 1'b0);
    step("ld_f2", X_F2, 1'b0);
    step("ld_dec", X_DEC, 1'b0);
    step("ld_e3", X_AE3, 1'b0);
    step("ld_e4", X_AE4, 1'b0);
    step("ld_e5", X_ME5, 1'b0);
    step("ld_e6_w1", X_LE6, 1'b1);
    step("ld_e6_w2", X_LE6, 1'b1);
    step("ld_e6", X_LE6, 1'b0);
    step("ld_e7", X_LE7, 1'b0);
    step("ld_f0", X_F0, 1'b0);
    check("ld_latency", 25'(ncyc), 25'd13);
    check("ld_pcinc_once", 25'(pcinc), 25'd1);

    // st: store E7 held 2 extra cycles by mem_wait
    IR_Data = ir(5'b00010);
    ncyc = 0;
    step("st_f1", X_F1, 1'b0);
    step("st_f2", X_F2, 1'b0);
    step("st_dec", X_DEC, 1'b0);
    step("st_e3", X_AE3, 1'b0);
    step("st_e4", X_AE4, 1'b0);
    step("st_e5", X_ME5, 1'b0);
    step("st_e6", X_SE6, 1'b0);
    step("st_e7_w1", X_SE7, 1'b1);
    step("st_e7_w2", X_SE7, 1'b1);
    step("st_e7", X_SE7, 1'b0);
    step("st_f0", X_F0, 1'b0);
    check("st_latency", 25'(ncyc), 25'd11);

    // illegal opcode 11111
    IR_Data = ir(5'b11111);
    step("ill_f1", X_F1, 1'b0);
    step("ill_f2", X_F2, 1'b0);
    step("ill_dec", X_DECI, 1'b0);
    step("ill_f0", X_F0, 1'b0);

    // halt, then restart
    IR_Data = ir(5'b11011);
    step("halt_f1", X_F1, 1'b0);
    step("halt_f2", X_F2, 1'b0);
    step("halt_dec", X_DEC, 1'b0);
    step("halt_s1", X_IDLE, 1'b0);
    step("halt_s2", X_IDLE, 1'b0);
    IR_Data = ir(5'b00001);
    start = 1'b1;
    step("halt_resume_f0", X_F0, 1'b0);
    start = 1'b0;

    // ldi interrupted by reset in E5
    step("rst_f1", X_F1, 1'b0);
    step("rst_f2", X_F2, 1'b0);
    step("rst_dec", X_DEC, 1'b0);
    step("rst_e3", X_AE3, 1'b0);
    step("rst_e4", X_AE4, 1'b0);
    step("rst_e5", X_WB5, 1'b0);
    #1;
    reset_n = 1'b0;
    start = 1'b1;
    #1;
    check("rst_async_drop", ctrl, X_IDLE);
    step("rst_start_ignored", X_IDLE, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    start = 1'b0;
    step("rst_idle1", X_IDLE, 1'b0);
    step("rst_idle2", X_IDLE, 1'b0);
    start = 1'b1;
    step("rst_restart_f0", X_F0, 1'b0);
    start = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
